fetch_pack: RTL and testbench
=============================

FETCH_PACK -- requirements
Module: fetch_pack

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0, giving the fetch PC loaded at reset (bits [1:0] ignored).
REQ-002 SHALL have port clock  input  1  sole clock, rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port flush_rt_i  input  1  retire-stage flush/redirect strobe.
REQ-005 SHALL have port redirect_pc_i  input  64  new fetch PC, sampled when flush_rt_i=1.
REQ-006 SHALL have port ic_req_vld_o  output  1  I-cache request valid.
REQ-007 SHALL have port ic_req_pc_o  output  64  request address, 32-byte aligned.
REQ-008 SHALL have port ic_req_rdy_i  input  1  I-cache request accepted.
REQ-009 SHALL have port ic_rsp_vld_i  input  1  I-cache response valid, exactly one per accepted request.
REQ-010 SHALL have port ic_rsp_data_i  input  256  fetch line; word i = bits [32i+31:32i].
REQ-011 SHALL have ports inst0_o..inst7_o  output  32 each  packed instruction group.
REQ-012 SHALL have port inst_vld_o  output  8  group valid mask, bit j = inst j.
REQ-013 SHALL have port pc_f2_o  output  64  PC of inst0_o.
REQ-014 SHALL have port inst_q_full_i  input  1  instruction buffer full (backpressure).

Function
REQ-015 SHALL run FSM states S_REQ, S_WAIT, S_PACK, S_DRAIN, entering S_REQ out of reset.
REQ-016 In S_REQ, ic_req_vld_o=1 and ic_req_pc_o={fetch_pc[63:5],5'b0}; on ic_req_rdy_i=1 -> S_WAIT, else stay.
REQ-017 In S_WAIT, on ic_rsp_vld_i=1 SHALL capture ic_rsp_data_i into line register and go to S_PACK.
REQ-018 Transfer SHALL occur in any cycle where inst_vld_o[0]=1 and inst_q_full_i=0; output slot is free when inst_vld_o=0 or a transfer occurs that cycle.
REQ-019 In S_PACK with slot free: k=fetch_pc[4:2]; inst j_o <= line word k+j for j<8-k, else 32'h0; inst_vld_o <= 8'hFF>>k; pc_f2_o <= fetch_pc; fetch_pc <= {fetch_pc[63:5]+1,5'b0}; -> S_REQ.
REQ-020 In S_PACK with slot not free SHALL hold line, fetch_pc and state.
REQ-021 inst_vld_o SHALL always be contiguous from bit 0 (pattern 0..01..1 or 8'h00).
REQ-022 Transfer without new load SHALL clear inst_vld_o to 8'h00 next cycle; outputs otherwise hold stable while inst_q_full_i=1.
REQ-023 Response-to-output latency SHALL be 2 cycles when slot free (rsp at cycle N, inst_vld_o valid at N+2).
REQ-024 fetch_pc address arithmetic SHALL wrap modulo 2^64.
REQ-025 flush_rt_i=1 SHALL, next cycle: clear inst_vld_o and instruction outputs to 0, fetch_pc <= {redirect_pc_i[63:2],2'b00}, discard line register; flush has priority over all other events that cycle.
REQ-026 On flush, next state SHALL be S_DRAIN if a response is outstanding (state S_WAIT with ic_rsp_vld_i=0, or S_REQ with ic_req_rdy_i=1), else S_REQ.
REQ-027 In S_DRAIN, SHALL keep ic_req_vld_o=0, drop the next ic_rsp_vld_i response, then -> S_REQ; flush in S_DRAIN only updates fetch_pc.
REQ-028 A response arriving in the same cycle as a flush in S_WAIT SHALL be dropped.

Reset
REQ-029 While reset=1: state S_REQ, fetch_pc=RESET_PC&~3, line register 0, inst0_o..inst7_o=0, inst_vld_o=8'h00, pc_f2_o=0, ic_req_vld_o=0.
REQ-030 Reset asserted mid-request SHALL abandon the outstanding response; the I-cache is reset concurrently.

Configuration
REQ-031 With FETCH_PACK_PERF_CNT_EN defined, SHALL add outputs grp_cnt_o (32) counting transfers and stall_cnt_o (32) counting cycles with inst_vld_o[0]=1 and inst_q_full_i=1; both wrap, clear on reset and not on flush.
REQ-032 Without FETCH_PACK_PERF_CNT_EN, those ports and counters SHALL be absent and behaviour otherwise identical.

Verification
REQ-033 Reset RESET_PC=64'h1000, rdy=1, rsp 1 cycle after request -> ic_req_pc_o=64'h1000, inst_vld_o=8'hFF, pc_f2_o=64'h1000, next request 64'h1020.
REQ-034 Flush with redirect_pc_i=64'h2014 -> request 64'h2000, inst0_o=word 5, inst_vld_o=8'h07, pc_f2_o=64'h2014.
REQ-035 inst_q_full_i=1 for 5 cycles with group pending -> outputs stable, no new request; stall_cnt_o +5 when macro defined.
REQ-036 Flush while S_WAIT, rsp 3 cycles later -> stale rsp dropped, single new request to redirect line, no stale instructions visible.
REQ-037 Flush coincident with ic_rsp_vld_i in S_WAIT -> rsp dropped, S_REQ next cycle, no S_DRAIN.
REQ-038 fetch_pc=64'hFFFF_FFFF_FFFF_FFE0 -> group delivered, next request 64'h0.

Source files
------------

// File: rtl/fetch_pack.sv
// fetch_pack: fetch-line requester and instruction-group packer.
// Requests 32-byte lines from the I-cache, then packs the line into a group of
// up to eight instructions, starting at the fetch PC's word offset.
// Ports:
//   clock, reset             clock (rising edge), asynchronous active-high reset
//   flush_rt_i, redirect_pc_i retire-stage redirect strobe and target PC
//   ic_req_vld_o/_pc_o/_rdy_i I-cache request handshake (line-aligned address)
//   ic_rsp_vld_i, ic_rsp_data_i I-cache response (one per accepted request)
//   inst0_o..inst7_o, inst_vld_o, pc_f2_o  packed group, contiguous valid mask, group PC
//   inst_q_full_i            instruction buffer backpressure
//   grp_cnt_o, stall_cnt_o   perf counters, present only with FETCH_PACK_PERF_CNT_EN
module fetch_pack #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         flush_rt_i,
    input  logic [63:0]  redirect_pc_i,
    output logic         ic_req_vld_o,
    output logic [63:0]  ic_req_pc_o,
    input  logic         ic_req_rdy_i,
    input  logic         ic_rsp_vld_i,
    input  logic [255:0] ic_rsp_data_i,
    output logic [31:0]  inst0_o,
    output logic [31:0]  inst1_o,
    output logic [31:0]  inst2_o,
    output logic [31:0]  inst3_o,
    output logic [31:0]  inst4_o,
    output logic [31:0]  inst5_o,
    output logic [31:0]  inst6_o,
    output logic [31:0]  inst7_o,
    output logic [7:0]   inst_vld_o,
    output logic [63:0]  pc_f2_o,
    input  logic         inst_q_full_i
`ifdef FETCH_PACK_PERF_CNT_EN
    ,
    output logic [31:0]  grp_cnt_o,
    output logic [31:0]  stall_cnt_o
`endif
);
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_PACK, S_DRAIN} state_t;
    state_t state, state_nx;
    logic [63:0] fetch_pc;
    logic [255:0] line;
    logic [7:0][31:0] insts;
    logic accepted, xfer, slot_free, rsp_pending;
    assign accepted = ic_req_vld_o & ic_req_rdy_i;
    assign xfer = inst_vld_o[0] & ~inst_q_full_i;
    // the mask is contiguous from bit 0, so bit 0 alone says whether a group is held
    assign slot_free = ~inst_vld_o[0] | ~inst_q_full_i;
    assign rsp_pending = (state == S_WAIT && !ic_rsp_vld_i) || (state == S_REQ && accepted);
    assign ic_req_pc_o = {fetch_pc[63:5], 5'b0};
    assign {inst7_o, inst6_o, inst5_o, inst4_o, inst3_o, inst2_o, inst1_o, inst0_o} = insts;
    always_comb begin
        state_nx = state;
        case (state)
            S_REQ:   state_nx = accepted ? S_WAIT : S_REQ;
            S_WAIT:  state_nx = ic_rsp_vld_i ? S_PACK : S_WAIT;
            S_PACK:  state_nx = slot_free ? S_REQ : S_PACK;
            default: state_nx = ic_rsp_vld_i ? S_REQ : S_DRAIN;
        endcase
        // a redirect must still swallow a response the I-cache owes us
        if (flush_rt_i && state != S_DRAIN)
            state_nx = rsp_pending ? S_DRAIN : S_REQ;
    end
    // request valid is registered so it stays low while reset is asserted
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_REQ;
            ic_req_vld_o <= 1'b0;
            fetch_pc <= RESET_PC & ~64'h3;
            line <= '0;
            insts <= '0;
            inst_vld_o <= 8'h00;
            pc_f2_o <= 64'h0;
        end else begin
            state <= state_nx;
            ic_req_vld_o <= state_nx == S_REQ;
            if (flush_rt_i) begin
                fetch_pc <= redirect_pc_i & ~64'h3;
                line <= '0;
                insts <= '0;
                inst_vld_o <= 8'h00;
            end else begin
                if (state == S_WAIT && ic_rsp_vld_i)
                    line <= ic_rsp_data_i;
                if (state == S_PACK && slot_free) begin
                    // shifting the whole line down leaves zeros in the slots past the line end
                    insts <= line >> {fetch_pc[4:2], 5'b0};
                    inst_vld_o <= 8'hFF >> fetch_pc[4:2];
                    pc_f2_o <= fetch_pc;
                    fetch_pc <= {fetch_pc[63:5] + 59'd1, 5'b0};
                end else if (xfer) begin
                    inst_vld_o <= 8'h00;
                end
            end
        end
    end
`ifdef FETCH_PACK_PERF_CNT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            grp_cnt_o <= 32'h0;
            stall_cnt_o <= 32'h0;
        end else begin
            grp_cnt_o <= grp_cnt_o + {31'h0, xfer};
            stall_cnt_o <= stall_cnt_o + {31'h0, inst_vld_o[0] & inst_q_full_i};
        end
    end
`endif
endmodule

// File: tb/tb_fetch_pack.sv
// tb_fetch_pack: directed self-checking bench for fetch_pack.
module tb_fetch_pack;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic flush_rt_i = 1'b0;
    logic [63:0] redirect_pc_i = 64'h0;
    logic ic_req_vld_o;
    logic [63:0] ic_req_pc_o;
    logic ic_req_rdy_i = 1'b0;
    logic ic_rsp_vld_i = 1'b0;
    logic [255:0] ic_rsp_data_i = '0;
    logic [31:0] inst0_o, inst1_o, inst2_o, inst3_o, inst4_o, inst5_o, inst6_o, inst7_o;
    logic [7:0] inst_vld_o;
    logic [63:0] pc_f2_o;
    logic inst_q_full_i = 1'b0;
`ifdef FETCH_PACK_PERF_CNT_EN
    logic [31:0] grp_cnt_o, stall_cnt_o;
`endif
    int checks = 0;
    int failures = 0;

    fetch_pack #(.RESET_PC(64'h1000)) dut (
        .clock(clock), .reset(reset), .flush_rt_i(flush_rt_i), .redirect_pc_i(redirect_pc_i),
        .ic_req_vld_o(ic_req_vld_o), .ic_req_pc_o(ic_req_pc_o), .ic_req_rdy_i(ic_req_rdy_i),
        .ic_rsp_vld_i(ic_rsp_vld_i), .ic_rsp_data_i(ic_rsp_data_i),
        .inst0_o(inst0_o), .inst1_o(inst1_o), .inst2_o(inst2_o), .inst3_o(inst3_o),
        .inst4_o(inst4_o), .inst5_o(inst5_o), .inst6_o(inst6_o), .inst7_o(inst7_o),
        .inst_vld_o(inst_vld_o), .pc_f2_o(pc_f2_o), .inst_q_full_i(inst_q_full_i)
`ifdef FETCH_PACK_PERF_CNT_EN
        , .grp_cnt_o(grp_cnt_o), .stall_cnt_o(stall_cnt_o)
`endif
    );

    always #5 clock = ~clock;

    function automatic logic [255:0] mk_line(input logic [31:0] b);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[32*i +: 32] = b + i;
        return l;
    endfunction

    task automatic do_reset(input logic full, input logic rdy);
        @(negedge clock);
        reset = 1'b1;
        flush_rt_i = 1'b0;
        ic_rsp_vld_i = 1'b0;
        ic_req_rdy_i = rdy;
        inst_q_full_i = full;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic wait_req(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clock);
            ok = ic_req_vld_o;
        end
    endtask

    task automatic test_basic();
        logic ok;
        do_reset(1'b0, 1'b1);
        wait_req(ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL basic_req_timeout got=%b exp=1", ok); end
        checks++; if (ic_req_pc_o !== 64'h1000) begin failures++; $display("FAIL basic_req_pc got=%h exp=%h", ic_req_pc_o, 64'h1000); end
        @(negedge clock);
        ic_req_rdy_i = 1'b0;
        ic_rsp_vld_i = 1'b1;
        ic_rsp_data_i = mk_line(32'h100);
        @(negedge clock);
        ic_rsp_vld_i = 1'b0;
        checks++; if (inst_vld_o !== 8'h00) begin failures++; $display("FAIL basic_early_vld got=%h exp=00", inst_vld_o); end
        @(negedge clock);
        checks++; if (inst_vld_o !== 8'hFF) begin failures++; $display("FAIL basic_vld got=%h exp=ff", inst_vld_o); end
        checks++; if (pc_f2_o !== 64'h1000) begin failures++; $display("FAIL basic_pc_f2 got=%h exp=%h", pc_f2_o, 64'h1000); end
        checks++; if (inst0_o !== 32'h100) begin failures++; $display("FAIL basic_inst0 got=%h exp=100", inst0_o); end
        checks++; if (inst7_o !== 32'h107) begin failures++; $display("FAIL basic_inst7 got=%h exp=107", inst7_o); end
        checks++; if (ic_req_vld_o !== 1'b1 || ic_req_pc_o !== 64'h1020) begin failures++; $display("FAIL basic_next_req got=%b/%h exp=1/%h", ic_req_vld_o, ic_req_pc_o, 64'h1020); end
        @(negedge clock);
        checks++; if (inst_vld_o !== 8'h00) begin failures++; $display("FAIL basic_clear_after_xfer got=%h exp=00", inst_vld_o); end
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checks++; if (ic_req_vld_o !== 1'b0) begin failures++; $display("FAIL reset_req_vld got=%b exp=0", ic_req_vld_o); end
        checks++; if (inst_vld_o !== 8'h00) begin failures++; $display("FAIL reset_vld got=%h exp=00", inst_vld_o); end
        checks++; if (pc_f2_o !== 64'h0) begin failures++; $display("FAIL reset_pc_f2 got=%h exp=0", pc_f2_o); end
        checks++; if (inst0_o !== 32'h0 || inst7_o !== 32'h0) begin failures++; $display("FAIL reset_insts got=%h/%h exp=0/0", inst0_o, inst7_o); end
        checks++; if (ic_req_pc_o !== 64'h1000) begin failures++; $display("FAIL reset_fetch_pc got=%h exp=%h", ic_req_pc_o, 64'h1000); end
`ifdef FETCH_PACK_PERF_CNT_EN
        checks++; if (grp_cnt_o !== 32'h0 || stall_cnt_o !== 32'h0) begin failures++; $display("FAIL reset_cnts got=%h/%h exp=0/0", grp_cnt_o, stall_cnt_o); end
`endif
        reset = 1'b0;
    endtask

    task automatic test_flush_offset();
        logic ok;
        do_reset(1'b0, 1'b0);
        wait_req(ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL offset_req_timeout got=%b exp=1", ok); end
        flush_rt_i = 1'b1;
        redirect_pc_i = 64'h2014;
        @(negedge clock);
        flush_rt_i = 1'b0;
        checks++; if (ic_req_vld_o !== 1'b1 || ic_req_pc_o !== 64'h2000) begin failures++; $display("FAIL offset_req got=%b/%h exp=1/%h", ic_req_vld_o, ic_req_pc_o, 64'h2000); end
        ic_req_rdy_i = 1'b1;
        @(negedge clock);
        ic_req_rdy_i = 1'b0;
        ic_rsp_vld_i = 1'b1;
        ic_rsp_data_i = mk_line(32'h200);
        @(negedge clock);
        ic_rsp_vld_i = 1'b0;
        @(negedge clock);
        checks++; if (inst_vld_o !== 8'h07) begin failures++; $display("FAIL offset_vld got=%h exp=07", inst_vld_o); end
        checks++; if (inst0_o !== 32'h205 || inst2_o !== 32'h207) begin failures++; $display("FAIL offset_insts got=%h/%h exp=205/207", inst0_o, inst2_o); end
        checks++; if (inst3_o !== 32'h0 || inst7_o !== 32'h0) begin failures++; $display("FAIL offset_zero_fill got=%h/%h exp=0/0", inst3_o, inst7_o); end
        checks++; if (pc_f2_o !== 64'h2014) begin failures++; $display("FAIL offset_pc_f2 got=%h exp=%h", pc_f2_o, 64'h2014); end
        checks++; if (ic_req_pc_o !== 64'h2020) begin failures++; $display("FAIL offset_next_req got=%h exp=%h", ic_req_pc_o, 64'h2020); end
    endtask

    task automatic test_backpressure();
        logic ok;
`ifdef FETCH_PACK_PERF_CNT_EN
        logic [31:0] s0;
`endif
        do_reset(1'b1, 1'b1);
        wait_req(ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL bp_req_timeout got=%b exp=1", ok); end
        @(negedge clock);
        ic_rsp_vld_i = 1'b1;
        ic_rsp_data_i = mk_line(32'h300);
        @(negedge clock);
        ic_rsp_vld_i = 1'b0;
        @(negedge clock);
        checks++; if (inst_vld_o !== 8'hFF || inst0_o !== 32'h300) begin failures++; $display("FAIL bp_first_group got=%h/%h exp=ff/300", inst_vld_o, inst0_o); end
        @(negedge clock);
        ic_req_rdy_i = 1'b0;
        ic_rsp_vld_i = 1'b1;
        ic_rsp_data_i = mk_line(32'h400);
        @(negedge clock);
        ic_rsp_vld_i = 1'b0;
`ifdef FETCH_PACK_PERF_CNT_EN
        s0 = stall_cnt_o;
`endif
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            checks++; if (inst_vld_o !== 8'hFF || inst0_o !== 32'h300 || pc_f2_o !== 64'h1000) begin failures++; $display("FAIL bp_hold[%0d] got=%h/%h/%h exp=ff/300/1000", i, inst_vld_o, inst0_o, pc_f2_o); end
            checks++; if (ic_req_vld_o !== 1'b0) begin failures++; $display("FAIL bp_no_req[%0d] got=%b exp=0", i, ic_req_vld_o); end
        end
`ifdef FETCH_PACK_PERF_CNT_EN
        checks++; if (stall_cnt_o !== s0 + 32'd5) begin failures++; $display("FAIL bp_stall_cnt got=%0d exp=%0d", stall_cnt_o, s0 + 32'd5); end
`endif
        inst_q_full_i = 1'b0;
        @(negedge clock);
        checks++; if (inst_vld_o !== 8'hFF || inst0_o !== 32'h400 || pc_f2_o !== 64'h1020) begin failures++; $display("FAIL bp_second_group got=%h/%h/%h exp=ff/400/1020", inst_vld_o, inst0_o, pc_f2_o); end
        checks++; if (ic_req_pc_o !== 64'h1040) begin failures++; $display("FAIL bp_next_req got=%h exp=%h", ic_req_pc_o, 64'h1040); end
`ifdef FETCH_PACK_PERF_CNT_EN
        checks++; if (grp_cnt_o !== 32'd1) begin failures++; $display("FAIL bp_grp_cnt got=%0d exp=1", grp_cnt_o); end
`endif
    endtask

    task automatic test_flush_wait();
        logic ok;
        do_reset(1'b0, 1'b1);
        wait_req(ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL fw_req_timeout got=%b exp=1", ok); end
        @(negedge clock);
        ic_req_rdy_i = 1'b0;
        flush_rt_i = 1'b1;
        redirect_pc_i = 64'h3040;
        @(negedge clock);
        flush_rt_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (ic_req_vld_o !== 1'b0 || inst_vld_o !== 8'h00) begin failures++; $display("FAIL fw_drain[%0d] got=%b/%h exp=0/00", i, ic_req_vld_o, inst_vld_o); end
            if (i < 2) @(negedge clock);
        end
        ic_rsp_vld_i = 1'b1;
        ic_rsp_data_i = mk_line(32'h500);
        @(negedge clock);
        ic_rsp_vld_i = 1'b0;
        checks++; if (ic_req_vld_o !== 1'b1 || ic_req_pc_o !== 64'h3040) begin failures++; $display("FAIL fw_new_req got=%b/%h exp=1/%h", ic_req_vld_o, ic_req_pc_o, 64'h3040); end
        checks++; if (inst_vld_o !== 8'h00) begin failures++; $display("FAIL fw_stale_vld got=%h exp=00", inst_vld_o); end
        ic_req_rdy_i = 1'b1;
        @(negedge clock);
        ic_req_rdy_i = 1'b0;
        checks++; if (ic_req_vld_o !== 1'b0) begin failures++; $display("FAIL fw_single_req got=%b exp=0", ic_req_vld_o); end
        ic_rsp_vld_i = 1'b1;
        ic_rsp_data_i = mk_line(32'h600);
        @(negedge clock);
        ic_rsp_vld_i = 1'b0;
        @(negedge clock);
        checks++; if (inst_vld_o !== 8'hFF || inst0_o !== 32'h600 || pc_f2_o !== 64'h3040) begin failures++; $display("FAIL fw_group got=%h/%h/%h exp=ff/600/3040", inst_vld_o, inst0_o, pc_f2_o); end
    endtask

    task automatic test_flush_rsp();
        logic ok;
        do_reset(1'b0, 1'b1);
        wait_req(ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL fr_req_timeout got=%b exp=1", ok); end
        @(negedge clock);
        ic_req_rdy_i = 1'b0;
        flush_rt_i = 1'b1;
        redirect_pc_i = 64'h4000;
        ic_rsp_vld_i = 1'b1;
        ic_rsp_data_i = mk_line(32'h700);
        @(negedge clock);
        flush_rt_i = 1'b0;
        ic_rsp_vld_i = 1'b0;
        checks++; if (ic_req_vld_o !== 1'b1 || ic_req_pc_o !== 64'h4000) begin failures++; $display("FAIL fr_req got=%b/%h exp=1/%h", ic_req_vld_o, ic_req_pc_o, 64'h4000); end
        checks++; if (inst_vld_o !== 8'h00) begin failures++; $display("FAIL fr_vld got=%h exp=00", inst_vld_o); end
        ic_req_rdy_i = 1'b1;
        @(negedge clock);
        ic_req_rdy_i = 1'b0;
        ic_rsp_vld_i = 1'b1;
        ic_rsp_data_i = mk_line(32'h800);
        @(negedge clock);
        ic_rsp_vld_i = 1'b0;
        @(negedge clock);
        checks++; if (inst0_o !== 32'h800 || pc_f2_o !== 64'h4000) begin failures++; $display("FAIL fr_group got=%h/%h exp=800/4000", inst0_o, pc_f2_o); end
    endtask

    task automatic test_wrap();
        logic ok;
        do_reset(1'b1, 1'b0);
        wait_req(ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL wrap_req_timeout got=%b exp=1", ok); end
        flush_rt_i = 1'b1;
        redirect_pc_i = 64'hFFFF_FFFF_FFFF_FFE0;
        @(negedge clock);
        flush_rt_i = 1'b0;
        checks++; if (ic_req_pc_o !== 64'hFFFF_FFFF_FFFF_FFE0) begin failures++; $display("FAIL wrap_req got=%h exp=ffffffffffffffe0", ic_req_pc_o); end
        ic_req_rdy_i = 1'b1;
        @(negedge clock);
        ic_req_rdy_i = 1'b0;
        ic_rsp_vld_i = 1'b1;
        ic_rsp_data_i = mk_line(32'h900);
        @(negedge clock);
        ic_rsp_vld_i = 1'b0;
        @(negedge clock);
        checks++; if (inst_vld_o !== 8'hFF || inst7_o !== 32'h907 || pc_f2_o !== 64'hFFFF_FFFF_FFFF_FFE0) begin failures++; $display("FAIL wrap_group got=%h/%h/%h exp=ff/907/ffffffffffffffe0", inst_vld_o, inst7_o, pc_f2_o); end
        checks++; if (ic_req_pc_o !== 64'h0) begin failures++; $display("FAIL wrap_next_req got=%h exp=0", ic_req_pc_o); end
        flush_rt_i = 1'b1;
        redirect_pc_i = 64'h5007;
        @(negedge clock);
        flush_rt_i = 1'b0;
        checks++; if (inst_vld_o !== 8'h00 || inst0_o !== 32'h0 || inst7_o !== 32'h0) begin failures++; $display("FAIL wrap_flush_clear got=%h/%h/%h exp=00/0/0", inst_vld_o, inst0_o, inst7_o); end
        checks++; if (ic_req_pc_o !== 64'h5000) begin failures++; $display("FAIL wrap_flush_req got=%h exp=%h", ic_req_pc_o, 64'h5000); end
    endtask

    initial begin
        test_basic();
        test_reset();
        test_flush_offset();
        test_backpressure();
        test_flush_wait();
        test_flush_rsp();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
